// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared read-owner encoding and default starvation limit for the dmem arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_e;
  localparam int STARVE_MAX_DEFAULT = 4;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: counts consecutive cycles the DMA loses to the CPU, saturating at STARVE_MAX.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  localparam int CW = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dma_req_i,
  input  logic          cpu_gnt_i,
  input  logic          dma_gnt_i,
  input  logic          hold_i,
  output logic          force_dma_o,
  output logic [CW-1:0] cnt_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (hold_i || !dma_req_i || dma_gnt_i) ? '0
          : (cpu_gnt_i && cnt_q != CW'(STARVE_MAX)) ? cnt_q + CW'(1)
          : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign force_dma_o = (cnt_q == CW'(STARVE_MAX));
  assign cnt_o       = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority arbiter for the shared sync-read data memory with DMA starvation relief.
// Optional DMEM_ARB_LOCK_EN adds dma_lock for atomic DMA bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          dma_lock,
`endif
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic          force_dma;
  logic          lock;
  logic [CW-1:0] starve_cnt;
  rd_owner_e     rd_owner_q, rd_owner_d;
`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  // Lock persists only while the DMA keeps winning with dma_lock high.
  assign lock_d = dma_gnt && dma_lock;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif
  assign cpu_gnt = rst_n && cpu_req && !lock && !(dma_req && force_dma);
  assign dma_gnt = rst_n && dma_req && !cpu_gnt;
  dmem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .dma_req_i  (dma_req),
    .cpu_gnt_i  (cpu_gnt),
    .dma_gnt_i  (dma_gnt),
    .hold_i     (lock),
    .force_dma_o(force_dma),
    .cnt_o      (starve_cnt)
  );
  always_comb begin
    mem_en    = cpu_gnt || dma_gnt;
    mem_we    = cpu_gnt ? cpu_we    : dma_gnt ? dma_we    : 1'b0;
    mem_addr  = cpu_gnt ? cpu_addr  : dma_gnt ? dma_addr  : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    rd_owner_d = (cpu_gnt && !cpu_we) ? OWN_CPU
               : (dma_gnt && !dma_we) ? OWN_DMA
               : OWN_NONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_owner_q <= OWN_NONE;
    else        rd_owner_q <= rd_owner_d;
  end
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign dma_rvalid = (rd_owner_q == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant policy, starvation, read routing, writes and reset.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        dma_lock;
`endif
  logic [31:0] mem [16];
  int          pass_cnt = 0;
  int          total = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .dma_lock  (dma_lock),
`endif
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read memory macro model, word-indexed by addr[5:2].
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
`ifdef DMEM_ARB_LOCK_EN
    dma_lock = 0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'hCAFE_0000;
    mem[1] = 32'h0BAD_0004;
    mem[4] = 32'hDEAD_BEEF;
    mem_rdata = 0;
    idle();
    rst_n = 0;
    cpu_req = 1;
    #2;
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_starve", 32'(dut.starve_cnt), 0);
    check("rst_owner", 32'(dut.rd_owner_q), 0);
    idle();
    cyc();
    rst_n = 1;
    cyc();
    // CPU-only read of 0x10
    cpu_req = 1; cpu_addr = 32'h10;
    #1;
    check("cpu_rd_gnt", 32'(cpu_gnt), 1);
    check("cpu_rd_dma_gnt", 32'(dma_gnt), 0);
    check("cpu_rd_mem_en", 32'(mem_en), 1);
    check("cpu_rd_mem_addr", mem_addr, 32'h10);
    check("cpu_rd_mem_we", 32'(mem_we), 0);
    cyc();
    idle();
    #1;
    check("cpu_rd_rvalid", 32'(cpu_rvalid), 1);
    check("cpu_rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("cpu_rd_dma_rvalid", 32'(dma_rvalid), 0);
    check("cpu_rd_dma_rdata", dma_rdata, 0);
    check("idle_mem_en", 32'(mem_en), 0);
    check("idle_mem_addr", mem_addr, 0);
    cyc();
    check("cpu_rd_rvalid_done", 32'(cpu_rvalid), 0);
    // Contention: both hold requests; DMA forced on the fifth cycle
    cpu_req = 1; cpu_addr = 32'h8;
    dma_req = 1; dma_addr = 32'hC;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("cont_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'(c != 4));
      check($sformatf("cont_dma_gnt_c%0d", c), 32'(dma_gnt), 32'(c == 4));
      check($sformatf("cont_starve_c%0d", c), 32'(dut.starve_cnt), (c < 5) ? 32'(c) : 0);
      if (c == 1) check("cont_cpu_rdata_c1", cpu_rdata, 32'h1000_0002);
      if (c == 5) begin
        check("cont_dma_rvalid_c5", 32'(dma_rvalid), 1);
        check("cont_dma_rdata_c5", dma_rdata, 32'h1000_0003);
        check("cont_cpu_rvalid_c5", 32'(cpu_rvalid), 0);
      end
      cyc();
    end
    idle();
    cyc();
    // Back-to-back: CPU read 0x0 then DMA read 0x4
    cpu_req = 1; cpu_addr = 32'h0;
    #1;
    check("b2b_cpu_gnt", 32'(cpu_gnt), 1);
    cyc();
    idle();
    dma_req = 1; dma_addr = 32'h4;
    #1;
    check("b2b_dma_gnt", 32'(dma_gnt), 1);
    check("b2b_c1_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("b2b_c1_cpu_rdata", cpu_rdata, 32'hCAFE_0000);
    check("b2b_c1_dma_rvalid", 32'(dma_rvalid), 0);
    cyc();
    idle();
    #1;
    check("b2b_c2_dma_rvalid", 32'(dma_rvalid), 1);
    check("b2b_c2_dma_rdata", dma_rdata, 32'h0BAD_0004);
    check("b2b_c2_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("b2b_c2_cpu_rdata", cpu_rdata, 0);
    cyc();
    // DMA write, then read back
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
    #1;
    check("wr_dma_gnt", 32'(dma_gnt), 1);
    check("wr_mem_en", 32'(mem_en), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", mem_addr, 32'h20);
    check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc();
    idle();
    dma_req = 1; dma_addr = 32'h20;
    #1;
    check("wr_no_dma_rvalid", 32'(dma_rvalid), 0);
    check("wr_no_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rd_after_wr_mem_we", 32'(mem_we), 0);
    cyc();
    idle();
    #1;
    check("rd_after_wr_rvalid", 32'(dma_rvalid), 1);
    check("rd_after_wr_rdata", dma_rdata, 32'h1234_5678);
    cyc();
    // Reset while a CPU read is outstanding
    cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h8;
    #1;
    check("rmr_cpu_gnt_a", 32'(cpu_gnt), 1);
    cyc();
    check("rmr_starve_b", 32'(dut.starve_cnt), 1);
    check("rmr_cpu_gnt_b", 32'(cpu_gnt), 1);
    #1;
    rst_n = 0;
    #1;
    check("rmr_gnt_in_rst", 32'(cpu_gnt), 0);
    check("rmr_dma_gnt_in_rst", 32'(dma_gnt), 0);
    check("rmr_starve_rst", 32'(dut.starve_cnt), 0);
    check("rmr_owner_rst", 32'(dut.rd_owner_q), 0);
    cyc();
    check("rmr_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rmr_cpu_rdata", cpu_rdata, 0);
    idle();
    rst_n = 1;
    cyc();
`ifdef DMEM_ARB_LOCK_EN
    // Locked DMA burst holds off a continuously requesting CPU
    dma_req = 1; dma_addr = 32'h0; dma_lock = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("lock_dma_gnt_c%0d", c), 32'(dma_gnt), 1);
      check($sformatf("lock_cpu_gnt_c%0d", c), 32'(cpu_gnt), 0);
      check($sformatf("lock_starve_c%0d", c), 32'(dut.starve_cnt), 0);
      cyc();
      cpu_req = 1; cpu_addr = 32'h10;
    end
    dma_lock = 0;
    #1;
    check("lock_drop_dma_gnt", 32'(dma_gnt), 1);
    cyc();
    #1;
    check("lock_after_cpu_gnt", 32'(cpu_gnt), 1);
    check("lock_after_dma_gnt", 32'(dma_gnt), 0);
    idle();
    cyc();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous-read data memory between the CPU controller and a DMA/debug requester.
- CPU has fixed priority. A starvation counter forces a DMA grant after STARVE_MAX consecutive lost cycles.
- The block tracks the outstanding read owner and routes next-cycle read data back to the requester that issued the read.
- Sits between the CPU controller's dmem port, the DMA engine and the data memory macro.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, consecutive lost DMA cycles before DMA is forced to win (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request
cpu_we  input  1  CPU write enable (1=write, 0=read)
cpu_addr  input  AW  CPU byte address
cpu_wdata  input  DW  CPU write data
cpu_gnt  output  1  CPU access accepted this cycle
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  DW  CPU read data
dma_req  input  1  DMA access request
dma_we  input  1  DMA write enable
dma_addr  input  AW  DMA byte address
dma_wdata  input  DW  DMA write data
dma_gnt  output  1  DMA access accepted this cycle
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  DW  DMA read data
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid the cycle after a read enable

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - all gnt outputs 0 while rst_n low;
  - rvalid outputs 0, rdata outputs 0;
  - starve_cnt 0; rd_owner NONE.
- Grant is combinational and same-cycle: a request is accepted in the cycle where req && gnt.
  - A requester must hold req and its address/data stable until granted.
  - At most one gnt is high per cycle.
- Policy:
  - force_dma = (starve_cnt == STARVE_MAX).
  - cpu_gnt = cpu_req && !(dma_req && force_dma).
  - dma_gnt = dma_req && !cpu_gnt.
- Memory mux: mem_en = cpu_gnt|dma_gnt. mem_we, mem_addr and mem_wdata come from the winner; all are 0 when idle.
- starve_cnt:
  - increments, saturating at STARVE_MAX, when dma_req && cpu_gnt;
  - clears when dma_gnt or !dma_req.
- rd_owner register:
  - CPU on cpu_gnt&&!cpu_we;
  - DMA on dma_gnt&&!dma_we;
  - otherwise NONE.
- Read response, one cycle after the granted read:
  - owner's rvalid=1 and owner's rdata=mem_rdata;
  - the non-owner's rdata is 0.
  - Writes produce no rvalid.
- Back-to-back reads are fully pipelined, one per cycle. A response and a new grant may coincide in the same cycle.
- Reset mid-read: the pending response is dropped (rvalid never asserts).

Optional Feature:
- Macro DMEM_ARB_LOCK_EN.
- When defined:
  - adds input dma_lock (1 bit) and a lock_q register.
  - lock_q sets on dma_gnt&&dma_lock and clears when dma_lock or dma_req falls.
  - While lock_q is set, DMA wins over CPU and cpu_gnt=0, giving atomic DMA bursts. starve_cnt is held at 0.
- When undefined: no dma_lock port; the pure starvation policy above applies.

Decomposition:
- Shared package dmem_arb_pkg: rd_owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2; default STARVE_MAX.
- One sub-module is natural: dmem_arb_starve_ctr, the saturating counter exposing force_dma.
- Muxing and the response pipeline stay in the top module.

Test Plan:
- CPU only: cpu_req read @0x10 with a memory model returning 0xDEADBEEF -> cpu_gnt in cycle 0; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle 1; dma_rvalid=0 throughout.
- Contention: cpu_req and dma_req held high, STARVE_MAX=4 -> cpu_gnt in cycles 0-3, dma_gnt in cycle 4, cpu_gnt resumes in cycle 5 with starve_cnt cleared.
- Back-to-back reads: CPU read @0x0, then DMA read @0x4 forced in the next cycle -> in cycle 2 dma_rvalid=1 with the 0x4 data and cpu_rvalid=0; in cycle 1 cpu_rvalid=1 with the 0x0 data.
- Writes: DMA write 0x12345678 @0x20 while the CPU is idle -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; no rvalid in the next cycle.
- Reset mid-read: grant a CPU read, assert rst_n low before the next edge -> cpu_rvalid stays 0, rd_owner=NONE, starve_cnt=0.
- DMEM_ARB_LOCK_EN: DMA granted with dma_lock=1 while the CPU requests continuously -> dma_gnt stays high for 6 cycles with cpu_gnt=0; after dma_lock drops, cpu_gnt asserts the next cycle.
